// File: rtl/ddr_traffic_checker.sv
// Write-then-read-verify traffic generator for the MIG user interface.
// Writes an address-derived pattern over a window, reads it back and counts mismatches.
module ddr_traffic_checker #(
    parameter int unsigned          ADDR_W          = 25,
    parameter int unsigned          DATA_W          = 256,
    parameter logic [ADDR_W-1:0]    BASE_ADDR       = '0,
    parameter int unsigned          NUM_WORDS       = 1024,
    parameter int unsigned          MAX_OUTSTANDING = 16
) (
    input  logic                ui_clk,
    input  logic                cpu_resetn,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic                loop,
    output logic                busy,
    output logic                done,
    output logic [15:0]         pass_count,
    output logic [31:0]         err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_data,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                wr_en,
    input  logic                wr_busy,
    output logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_en,
    input  logic                rd_busy,
    input  logic [DATA_W-1:0]   rd_data,
    input  logic                rd_data_valid
);

    localparam int unsigned CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned OUT_W = PTR_W + 1;
    localparam int unsigned LANES = DATA_W / 32;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
    localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    // Expected data for word address a under pattern mode m.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic [1:0] m);
        logic [DATA_W-1:0] p;
        p = '0;
        case (m)
            2'd0:    p = DATA_W'(a);
            2'd1:    p = ~DATA_W'(a);
            2'd2:    p = DATA_W'(1) << (a % ADDR_W'(DATA_W));
            default: for (int k = 0; k < int'(LANES); k++) p[k*32 +: 32] = 32'(a) + 32'(k);
        endcase
        return p;
    endfunction

    state_t              state, state_nxt;
    logic [1:0]          mode_q;
    logic                loop_q;
    logic [CNT_W-1:0]    wr_idx, rd_idx;
    logic [ADDR_W-1:0]   tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]    tag_wptr, tag_rptr;
    logic [OUT_W-1:0]    outstanding, outstanding_nxt;
    logic                chk_vld, chk_spur;
    logic [ADDR_W-1:0]   chk_tag;
    logic [DATA_W-1:0]   chk_data;

    logic                start_acc, wr_fire, rd_fire, wr_last, rd_last;
    logic                tag_push, tag_pop, enter_write, enter_read, chk_err;
    logic [1:0]          wr_pat_mode;

    // Next state and per-cycle strobes.
    always_comb begin
        state_nxt       = state;
        start_acc       = start && ((state == S_IDLE) || (state == S_DONE));
        wr_fire         = wr_en && !wr_busy;
        rd_fire         = rd_en && !rd_busy;
        wr_last         = wr_fire && (wr_idx == LAST_IDX);
        rd_last         = rd_fire && (rd_idx == LAST_IDX);
        tag_push        = (state == S_READ) && rd_fire;
        tag_pop         = rd_data_valid && (state != S_IDLE) && (outstanding != '0);
        outstanding_nxt = outstanding + OUT_W'(tag_push) - OUT_W'(tag_pop);
        wr_pat_mode     = start_acc ? mode : mode_q;
        chk_err         = chk_vld && (chk_spur || (chk_data != pattern(chk_tag, mode_q)));

        case (state)
            S_IDLE, S_DONE: if (start_acc) state_nxt = S_WRITE;
            S_WRITE:        if (wr_last) state_nxt = S_READ;
            S_READ:         if (rd_last) state_nxt = S_DRAIN;
            S_DRAIN:        if (outstanding == '0) state_nxt = (loop_q && !stop) ? S_WRITE : S_DONE;
            default:        state_nxt = S_IDLE;
        endcase

        enter_write = (state_nxt == S_WRITE) && (state != S_WRITE);
        enter_read  = (state_nxt == S_READ) && (state != S_READ);
    end

    always_ff @(posedge ui_clk) begin
        if (!cpu_resetn) state <= S_IDLE;
        else             state <= state_nxt;
    end

    // Tag storage holds issued read addresses until their data returns.
    always_ff @(posedge ui_clk) begin
        if (tag_push) tag_mem[tag_wptr] <= rd_addr;
    end

    always_ff @(posedge ui_clk) begin
        if (!cpu_resetn) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_count     <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            wr_addr        <= '0;
            wr_data        <= '0;
            wr_en          <= 1'b0;
            rd_addr        <= '0;
            rd_en          <= 1'b0;
            mode_q         <= '0;
            loop_q         <= 1'b0;
            wr_idx         <= '0;
            rd_idx         <= '0;
            tag_wptr       <= '0;
            tag_rptr       <= '0;
            outstanding    <= '0;
            chk_vld        <= 1'b0;
            chk_spur       <= 1'b0;
            chk_tag        <= '0;
            chk_data       <= '0;
        end else begin
            busy <= (state_nxt == S_WRITE) || (state_nxt == S_READ) || (state_nxt == S_DRAIN);
            done <= (state_nxt == S_DONE);

            if (enter_write) begin
                wr_en   <= 1'b1;
                wr_idx  <= '0;
                wr_addr <= BASE_ADDR;
                wr_data <= pattern(BASE_ADDR, wr_pat_mode);
            end else if (wr_fire) begin
                if (wr_last) begin
                    wr_en <= 1'b0;
                end else begin
                    wr_idx  <= wr_idx + CNT_W'(1);
                    wr_addr <= wr_addr + ADDR_W'(1);
                    wr_data <= pattern(wr_addr + ADDR_W'(1), mode_q);
                end
            end

            // Reads throttle on the outstanding count as it will be after this edge.
            if (enter_read) begin
                rd_en   <= 1'b1;
                rd_idx  <= '0;
                rd_addr <= BASE_ADDR;
            end else if (state == S_READ) begin
                rd_en <= !rd_last && (outstanding_nxt < MAX_OUT);
                if (rd_fire) begin
                    rd_idx  <= rd_idx + CNT_W'(1);
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end

            if (tag_push) tag_wptr <= tag_wptr + PTR_W'(1);
            if (tag_pop)  tag_rptr <= tag_rptr + PTR_W'(1);
            outstanding <= outstanding_nxt;

            chk_vld <= rd_data_valid && (state != S_IDLE);
            if (rd_data_valid) begin
                chk_spur <= (outstanding == '0);
                chk_tag  <= tag_mem[tag_rptr];
                chk_data <= rd_data;
            end

            if (chk_err) begin
                if (err_count != '1) err_count <= err_count + 32'd1;
                if (err_count == '0) begin
                    first_err_addr <= chk_spur ? '1 : chk_tag;
                    first_err_data <= chk_data;
                end
            end

            if ((state == S_DRAIN) && (state_nxt != S_DRAIN)) pass_count <= pass_count + 16'd1;

            // A new run clears results; placed last so it wins over any pending update.
            if (start_acc) begin
                mode_q         <= mode;
                loop_q         <= loop;
                pass_count     <= '0;
                err_count      <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ddr_traffic_checker.sv
// Bench for ddr_traffic_checker: memory/latency model with scoreboarded writes and reads,
// a table of single-pass runs, then loop/stop, spurious-return and mid-run reset sequences.
module tb_ddr_traffic_checker;

    localparam int unsigned AW = 25;
    localparam int unsigned DW = 64;
    localparam int unsigned NW = 8;
    localparam int unsigned MO = 4;
    localparam logic [AW-1:0] BASE      = 25'h1FFFFFE;
    localparam logic [DW-1:0] FLIP      = 64'h0000_0100_0000_0000;
    localparam logic [DW-1:0] SPUR_DATA = 64'hDEAD_BEEF_0BAD_F00D;

    logic          ui_clk, cpu_resetn, start, stop, loop;
    logic [1:0]    mode;
    logic          busy, done, wr_en, wr_busy, rd_en, rd_busy, rd_data_valid;
    logic [15:0]   pass_count;
    logic [31:0]   err_count;
    logic [AW-1:0] first_err_addr, wr_addr, rd_addr;
    logic [DW-1:0] first_err_data, wr_data, rd_data;

    ddr_traffic_checker #(
        .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE), .NUM_WORDS(NW), .MAX_OUTSTANDING(MO)
    ) dut (
        .ui_clk(ui_clk), .cpu_resetn(cpu_resetn), .start(start), .stop(stop), .mode(mode),
        .loop(loop), .busy(busy), .done(done), .pass_count(pass_count), .err_count(err_count),
        .first_err_addr(first_err_addr), .first_err_data(first_err_data),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .wr_busy(wr_busy),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_busy(rd_busy),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
    typedef struct { logic [AW-1:0] addr; int due; } ret_t;
    typedef struct {
        logic [1:0]    mode;
        int            busy_pct;
        int            lat;
        int            flip_idx;
        logic [31:0]   exp_err;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } vec_t;

    wr_exp_t       exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    ret_t          ret_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    vec_t          vecs[6];

    int checks = 0, errors = 0;
    int cyc = 0, issued = 0, returned = 0;
    int busy_pct = 0, lat = 4, flip_idx = -1, ret_idx = 0;
    int spur_req = 0, spur_done = 0;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [1:0] m);
        case (m)
            2'd0:    return {39'b0, a};
            2'd1:    return ~{39'b0, a};
            2'd2:    return 64'd1 << a[5:0];
            default: return {32'(a) + 32'd1, 32'(a)};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge ui_clk);
    endtask

    // Controller model: random busy, in-order returns after lat cycles, transfer scoreboard.
    task automatic responder();
        ret_t          r;
        wr_exp_t       e;
        logic [DW-1:0] d;
        forever begin
            @(negedge ui_clk);
            cyc++;
            wr_busy = (int'($urandom_range(99)) < busy_pct);
            rd_busy = (int'($urandom_range(99)) < busy_pct);
            rd_data_valid = 1'b0;
            rd_data = '0;
            if (spur_done != spur_req) begin
                spur_done++;
                rd_data_valid = 1'b1;
                rd_data = SPUR_DATA;
            end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
                r = ret_q.pop_front();
                d = mem.exists(r.addr) ? mem[r.addr] : '0;
                if (ret_idx == flip_idx) d = d ^ FLIP;
                ret_idx++;
                returned++;
                rd_data_valid = 1'b1;
                rd_data = d;
            end
            if (cpu_resetn && wr_en && !wr_busy) begin
                mem[wr_addr] = wr_data;
                if (exp_wr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected: got addr 0x%0h want no write", wr_addr);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", wr_data, e.data);
                end
            end
            if (cpu_resetn && rd_en && !rd_busy) begin
                ret_q.push_back('{rd_addr, cyc + lat});
                issued++;
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got addr 0x%0h want no read", rd_addr);
                end else begin
                    check("rd_addr", 64'(rd_addr), 64'(exp_rd.pop_front()));
                end
                check("outstanding_le_max", 64'((issued - returned) <= int'(MO)), 64'd1);
            end
        end
    endtask

    task automatic push_pass(input logic [1:0] m);
        for (int i = 0; i < int'(NW); i++) begin
            logic [AW-1:0] a;
            a = BASE + AW'(i);
            exp_wr.push_back('{a, pat(a, m)});
            exp_rd.push_back(a);
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic lp);
        @(negedge ui_clk);
        mode = m; loop = lp; start = 1'b1;
        @(negedge ui_clk);
        start = 1'b0; mode = ~m; loop = ~lp;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge ui_clk);
            n++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        cpu_resetn = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; loop = 1'b0;
        wr_busy = 1'b0; rd_busy = 1'b0; rd_data = '0; rd_data_valid = 1'b0;

        vecs[0] = '{2'd0,  0,  4, -1, 32'd0, 25'd0, 64'd0};
        vecs[1] = '{2'd1, 30,  6, -1, 32'd0, 25'd0, 64'd0};
        vecs[2] = '{2'd2,  0,  4,  2, 32'd1, 25'd0, 64'h0000_0100_0000_0001};
        vecs[3] = '{2'd3, 50, 40, -1, 32'd0, 25'd0, 64'd0};
        vecs[4] = '{2'd3,  0,  4,  5, 32'd1, 25'd3, 64'h0000_0104_0000_0003};
        vecs[5] = '{2'd2, 50,  7, -1, 32'd0, 25'd0, 64'd0};

        fork
            responder();
            begin
                #2000000;
                $display("FAIL watchdog: got timeout want completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        tick(3);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_rd_en", 64'(rd_en), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_pass_count", 64'(pass_count), 64'd0);
        check("rst_first_err_addr", 64'(first_err_addr), 64'd0);
        cpu_resetn = 1'b1;
        tick(2);

        // Single-pass runs over the wrapping window.
        for (int v = 0; v < 6; v++) begin
            busy_pct = vecs[v].busy_pct;
            lat      = vecs[v].lat;
            flip_idx = vecs[v].flip_idx;
            ret_idx  = 0;
            push_pass(vecs[v].mode);
            start_run(vecs[v].mode, 1'b0);
            wait_done("run_done", 3000);
            check("run_busy", 64'(busy), 64'd0);
            check("run_pass_count", 64'(pass_count), 64'd1);
            check("run_err_count", 64'(err_count), 64'(vecs[v].exp_err));
            check("run_first_err_addr", 64'(first_err_addr), 64'(vecs[v].exp_addr));
            check("run_first_err_data", first_err_data, vecs[v].exp_data);
            check("run_wr_left", 64'(exp_wr.size()), 64'd0);
            check("run_rd_left", 64'(exp_rd.size()), 64'd0);
            tick(2);
        end

        // Looping run stopped during pass 3; a start while busy must be ignored.
        busy_pct = 0; lat = 4; flip_idx = -1; ret_idx = 0;
        push_pass(2'd1); push_pass(2'd1); push_pass(2'd1);
        start_run(2'd1, 1'b1);
        begin
            int n;
            n = 0;
            while (pass_count != 16'd2 && n < 2000) begin
                @(negedge ui_clk);
                n++;
            end
        end
        check("loop_reach_pass2", 64'(pass_count), 64'd2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        stop = 1'b1;
        wait_done("loop_done", 2000);
        stop = 1'b0;
        check("loop_pass_count", 64'(pass_count), 64'd3);
        check("loop_err_count", 64'(err_count), 64'd0);
        check("loop_wr_left", 64'(exp_wr.size()), 64'd0);
        check("loop_rd_left", 64'(exp_rd.size()), 64'd0);

        // Return with nothing outstanding while in DONE.
        spur_req++;
        tick(5);
        check("spur_err_count", 64'(err_count), 64'd1);
        check("spur_first_err_addr", 64'(first_err_addr), 64'h1FF_FFFF);
        check("spur_first_err_data", first_err_data, SPUR_DATA);
        check("spur_done_held", 64'(done), 64'd1);

        // Reset while reads are in flight; their late returns must be ignored.
        busy_pct = 0; lat = 40; flip_idx = -1; ret_idx = 0;
        push_pass(2'd0);
        start_run(2'd0, 1'b0);
        begin
            int n;
            n = 0;
            while ((issued - returned) != int'(MO) && n < 200) begin
                @(negedge ui_clk);
                n++;
            end
        end
        check("rst_mid_outstanding", 64'(issued - returned), 64'(MO));
        @(posedge ui_clk);
        #1 cpu_resetn = 1'b0;
        tick(2);
        cpu_resetn = 1'b1;
        exp_wr.delete();
        exp_rd.delete();
        tick(1);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_done", 64'(done), 64'd0);
        check("rst_mid_wr_en", 64'(wr_en), 64'd0);
        check("rst_mid_rd_en", 64'(rd_en), 64'd0);
        check("rst_mid_err_count", 64'(err_count), 64'd0);
        check("rst_mid_pass_count", 64'(pass_count), 64'd0);
        begin
            int n;
            n = 0;
            while (ret_q.size() > 0 && n < 200) begin
                @(negedge ui_clk);
                n++;
            end
        end
        check("late_returns_drained", 64'(ret_q.size()), 64'd0);
        tick(4);
        check("late_err_count", 64'(err_count), 64'd0);
        check("late_busy", 64'(busy), 64'd0);
        check("late_done", 64'(done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
